// File: rtl/tile_frame_renderer_pkg.sv
// Shared types and constants for the tile frame renderer.
// Holds the FSM state enum, lane-code width and colour constants.
package tile_frame_renderer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LANE_CODE_W = 3;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/tile_frame_renderer_scan.sv
// tile_scan_counter: row / dy / dx nested scan counter.
// Ports: clk, resetn, clear, advance, row_valid in; row, dy, dx, last out.
module tile_scan_counter #(
    parameter int NUM_ROWS   = 4,
    parameter int TILE_H     = 4,
    parameter int LANE_WIDTH = 20,
    localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int DYW = (TILE_H > 1) ? $clog2(TILE_H) : 1,
    localparam int DXW = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           clear,
    input  logic           advance,
    input  logic           row_valid,
    output logic [RW-1:0]  row,
    output logic [DYW-1:0] dy,
    output logic [DXW-1:0] dx,
    output logic           last
);

    logic dx_end;
    logic tile_end;

    // An invalid row occupies a single scan cycle.
    assign dx_end   = (dx == DXW'(LANE_WIDTH - 1));
    assign tile_end = !row_valid ||
                      (dx_end && dy == DYW'(TILE_H - 1));
    assign last     = (row == RW'(NUM_ROWS - 1)) && tile_end;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            row <= '0;
            dy  <= '0;
            dx  <= '0;
        end else if (advance) begin
            if (tile_end) begin
                row <= row + 1'b1;
                dy  <= '0;
                dx  <= '0;
            end else if (dx_end) begin
                dx <= '0;
                dy <= dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_frame_renderer.sv
// Per frame: erase the previous frame's tiles, then draw new rows of tiles.
// Ports: clk, resetn, start, offset, row_lanes, draw_colour in;
//        busy, done, x_out, y_out, c_out, writeEN out.
module tile_frame_renderer
    import tile_frame_renderer_pkg::*;
#(
    parameter int NUM_ROWS   = 4,
    parameter int NUM_LANES  = 4,
    parameter int LANE_X0    = 120,
    parameter int LANE_WIDTH = 20,
    parameter int TILE_H     = 4,
    parameter int ROW_PITCH  = 40,
    parameter int SCREEN_H   = 240,
    parameter int OFS_W      = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [OFS_W-1:0]      offset,
    input  logic [3*NUM_ROWS-1:0] row_lanes,
    input  logic [2:0]            draw_colour,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            x_out,
    output logic [7:0]            y_out,
    output logic [2:0]            c_out,
    output logic                  writeEN
);

    localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int DYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int DXW = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
    localparam int XW  = 10;
    localparam int YW  = 11;
    localparam int CW  = LANE_CODE_W;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    new_lanes [NUM_ROWS];
    logic [CW-1:0]    old_lanes [NUM_ROWS];
    logic [OFS_W-1:0] new_ofs;
    logic [OFS_W-1:0] old_ofs;
    logic [2:0]       colour;

    logic           clear;
    logic           advance;
    logic           row_valid;
    logic           last;
    logic [RW-1:0]  row;
    logic [DYW-1:0] dy;
    logic [DXW-1:0] dx;

    logic [CW-1:0]    code;
    logic [OFS_W-1:0] ofs;
    logic [2:0]       pix_colour;
    logic [XW-1:0]    px;
    logic [YW-1:0]    py;
    logic             scanning;
    logic             write;

    tile_scan_counter #(
        .NUM_ROWS   (NUM_ROWS),
        .TILE_H     (TILE_H),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .advance   (advance),
        .row_valid (row_valid),
        .row       (row),
        .dy        (dy),
        .dx        (dx),
        .last      (last)
    );

    // ERASE walks the previous frame in black, DRAW the new one.
    always_comb begin
        code       = old_lanes[row];
        ofs        = old_ofs;
        pix_colour = BLACK;
        if (state == DRAW) begin
            code       = new_lanes[row];
            ofs        = new_ofs;
            pix_colour = colour;
        end
    end

    assign row_valid = (code != '0) && (code <= CW'(NUM_LANES));
    assign scanning  = (state == ERASE) || (state == DRAW);
    assign advance   = scanning;

    assign px = XW'(LANE_X0)
              + (XW'(code) - XW'(1)) * XW'(LANE_WIDTH)
              + XW'(dx);
    assign py = YW'(row) * YW'(ROW_PITCH)
              + YW'(ofs)
              + YW'(dy);

    // Pixels below the screen or past the 9-bit x range are dropped,
    // but the scan cycle is still spent.
    assign write = scanning && row_valid
                && (py < YW'(SCREEN_H))
                && !px[XW-1];

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        unique case (state)
            IDLE: begin
                clear = 1'b1;
                if (start) state_next = ERASE;
            end
            ERASE: begin
                if (last) begin
                    clear      = 1'b1;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                new_lanes[r] <= '0;
                old_lanes[r] <= '0;
            end
            new_ofs <= '0;
            old_ofs <= '0;
            colour  <= BLACK;
        end else begin
            if (state == IDLE && start) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    new_lanes[r] <= row_lanes[3*r +: 3];
                end
                new_ofs <= offset;
                colour  <= draw_colour;
            end
            if (state == DONE) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    old_lanes[r] <= new_lanes[r];
                end
                old_ofs <= new_ofs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_out   <= '0;
            y_out   <= '0;
            c_out   <= '0;
            writeEN <= 1'b0;
        end else begin
            writeEN <= write;
            if (write) begin
                x_out <= px[8:0];
                y_out <= py[7:0];
                c_out <= pix_colour;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tile_frame_renderer.sv
// Scoreboard bench for tile_frame_renderer with a six-row instance.
// Expected pixels come from a frame-level model of erase and draw.
module tb_tile_frame_renderer;

    localparam int NR    = 6;
    localparam int NL    = 4;
    localparam int LX0   = 120;
    localparam int LW    = 20;
    localparam int TH    = 4;
    localparam int RP    = 40;
    localparam int SH    = 240;
    localparam int OFS_W = 6;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [OFS_W-1:0] offset;
    logic [3*NR-1:0]  row_lanes;
    logic [2:0]       draw_colour;
    logic             busy;
    logic             done;
    logic [8:0]       x_out;
    logic [7:0]       y_out;
    logic [2:0]       c_out;
    logic             writeEN;

    pix_t exp_q[$];
    int   old_l[NR];
    int   old_o;
    int   n_cmp;
    int   n_bad;

    tile_frame_renderer #(
        .NUM_ROWS   (NR),
        .NUM_LANES  (NL),
        .LANE_X0    (LX0),
        .LANE_WIDTH (LW),
        .TILE_H     (TH),
        .ROW_PITCH  (RP),
        .SCREEN_H   (SH),
        .OFS_W      (OFS_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .offset      (offset),
        .row_lanes   (row_lanes),
        .draw_colour (draw_colour),
        .busy        (busy),
        .done        (done),
        .x_out       (x_out),
        .y_out       (y_out),
        .c_out       (c_out),
        .writeEN     (writeEN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [3*NR-1:0] mk6(input int a, input int b,
                                            input int c, input int d,
                                            input int e, input int f);
        logic [3*NR-1:0] v;
        v = {3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
        return v;
    endfunction

    // Frame model: every tile of the old frame in black, then every
    // tile of the new frame in colour; count cycles per the scan rules.
    task automatic build_expected(input logic [3*NR-1:0] lanes,
                                  input int ofs, input int col,
                                  output int len, output int elen);
        int code, o, c, y;
        len  = 0;
        elen = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int r = 0; r < NR; r++) begin
                code = (ph == 1) ? int'(lanes[3*r +: 3]) : old_l[r];
                o    = (ph == 1) ? ofs : old_o;
                c    = (ph == 1) ? col : 0;
                if (code >= 1 && code <= NL) begin
                    for (int dy = 0; dy < TH; dy++)
                        for (int dx = 0; dx < LW; dx++) begin
                            y = r * RP + o + dy;
                            if (y < SH)
                                exp_q.push_back('{LX0 + (code - 1) * LW + dx,
                                                  y, c});
                        end
                    len += LW * TH;
                end else begin
                    len += 1;
                end
            end
            if (ph == 0) elen = len;
        end
        len += 1;
    endtask

    always @(negedge clk) begin
        pix_t e;
        if (resetn && writeEN) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pixel: got unexpected x=%0d y=%0d c=%0d, required no write",
                         x_out, y_out, c_out);
            end else begin
                e = exp_q.pop_front();
                if (int'(x_out) != e.x || int'(y_out) != e.y ||
                    int'(c_out) != e.c) begin
                    n_bad++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             x_out, y_out, c_out, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_x"}, int'(x_out), 0);
        chk({tag, "_y"}, int'(y_out), 0);
        chk({tag, "_c"}, int'(c_out), 0);
        chk({tag, "_wen"}, int'(writeEN), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // mode 0: single pulse, 1: start held, 2: random start during
    // the frame, 3: reset ten cycles into DRAW.
    task automatic run_frame(input logic [3*NR-1:0] lanes, input int ofs,
                             input int col, input int mode);
        int len, elen, cnt;
        bit seen, aborted;
        build_expected(lanes, ofs, col, len, elen);
        row_lanes   = lanes;
        offset      = OFS_W'(ofs);
        draw_colour = 3'(col);
        start       = 1'b1;
        @(negedge clk);
        if (mode != 1) start = 1'b0;
        row_lanes   = (3*NR)'($urandom);
        offset      = OFS_W'($urandom);
        draw_colour = 3'($urandom);
        cnt = 0;
        seen = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (busy) cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (mode == 3 && cnt == elen + 10) begin
                aborted = 1'b1;
                break;
            end
            if (mode == 2) start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            resetn = 1'b0;
            exp_q.delete();
            @(negedge clk);
            check_idle_zero("abort");
            resetn = 1'b1;
            for (int r = 0; r < NR; r++) old_l[r] = 0;
            old_o = 0;
            @(negedge clk);
            return;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got no done, required done after %0d cycles",
                     len);
        end else begin
            chk("frame_len", cnt, len);
            for (int r = 0; r < NR; r++) old_l[r] = int'(lanes[3*r +: 3]);
            old_o = ofs;
        end
        @(negedge clk);
        chk("q_drained", exp_q.size(), 0);
        chk("done_pulse", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("no_refire", int'(busy), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        old_o = 0;
        for (int r = 0; r < NR; r++) old_l[r] = 0;
        resetn      = 1'b0;
        start       = 1'b0;
        offset      = '0;
        row_lanes   = '0;
        draw_colour = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        run_frame(mk6(1, 0, 4, 0, 0, 0), 5, 7, 0);
        run_frame(mk6(2, 2, 2, 2, 2, 2), 6, 7, 0);
        run_frame(mk6(1, 0, 0, 0, 0, 3), 40, 2, 0);
        run_frame(mk6(5, 7, 1, 0, 0, 0), 20, 4, 1);
        run_frame(mk6(0, 0, 0, 0, 0, 0), 0, 1, 2);
        run_frame(mk6(3, 3, 3, 3, 3, 3), 10, 5, 3);
        run_frame(mk6(4, 1, 0, 2, 0, 3), 1, 6, 0);
        run_frame(mk6(4, 4, 4, 4, 4, 4), 63, 3, 0);

        for (int k = 0; k < 14; k++) begin
            run_frame((3*NR)'($urandom), $urandom_range(0, 63),
                      $urandom_range(0, 7), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
